// File: rtl/mca_segmented_acc_pkg.sv
// Shared types and the per-segment coefficient width reduction table for the
// segmented add/sub accumulator.
package mca_segmented_acc_pkg;

  localparam int RED_TABLE[8] = '{0, 1, 2, 3, 4, 5, 7, 8};

  typedef enum logic [1:0] {MCA_IDLE, MCA_ACCUM, MCA_REDUCE, MCA_DONE} mca_state_t;

  // Operand width of a lane in the given segment; segments past the table share its last entry
  function automatic int lane_width(input int full_width, input int seg);
    int seg_c;
    seg_c = (seg > 7) ? 7 : seg;
    return full_width - RED_TABLE[seg_c];
  endfunction

endpackage

// File: rtl/mca_segmented_acc_lane.sv
// One serial signed add/sub lane: steps through LANE_LEN operands, adding or
// subtracting each into a W_IN+ACC_GUARD bit wrapping accumulator.
module mca_seg_lane #(
  parameter int W_IN      = 32,
  parameter int LANE_LEN  = 16,
  parameter int ACC_GUARD = 4,
  localparam int SW       = (LANE_LEN > 1) ? $clog2(LANE_LEN) : 1,
  localparam int AW       = W_IN + ACC_GUARD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [SW-1:0]       step_i,
  input  logic [W_IN-1:0]     op_i [LANE_LEN],
  input  logic [LANE_LEN-1:0] add_i,
  output logic [AW-1:0]       acc_o
);

  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [W_IN-1:0] op_s;
  logic [AW-1:0]   op_ext_s;

  // Select this step's tap and form the next accumulator value
  always_comb begin
    op_s     = op_i[step_i];
    op_ext_s = {{ACC_GUARD{op_s[W_IN-1]}}, op_s};
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = add_i[step_i] ? (acc_q + op_ext_s) : (acc_q - op_ext_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Lane accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mca_segmented_acc.sv
// Time-multiplexed signed add/sub accumulator over K taps, grouped into reduced-width lanes.
// Define MCA_SAT_EN to clamp the final sample to the signed WIDTH_COEFFICIENT range.
module mca_segmented_acc
  import mca_segmented_acc_pkg::*;
#(
  parameter int K                 = 256,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int LANE_LEN          = 16,
  parameter int SEG_LEN           = 32,
  parameter int ACC_GUARD         = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                start_ready,
  input  logic signed [WIDTH_COEFFICIENT-1:0] H_matrix [K],
  input  logic [K-1:0]                        S_matrix,
  output logic signed [WIDTH_COEFFICIENT-1:0] sample,
  output logic                                sample_valid,
  input  logic                                sample_ready
);

  localparam int WC        = WIDTH_COEFFICIENT;
  localparam int NUM_LANES = K / LANE_LEN;
  localparam int HALF      = K / 2;
  localparam int ACC_W     = WC + $clog2(K) + ACC_GUARD;
  localparam int SW        = (LANE_LEN > 1) ? $clog2(LANE_LEN) : 1;
  localparam int LIW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  mca_state_t       state_q;
  logic [SW-1:0]    step_q;
  logic [LIW-1:0]   lane_idx_q;
  logic [K-1:0]     s_q;
  logic [ACC_W-1:0] red_acc_q;
  logic             start_ready_q;
  logic             sample_valid_q;
  logic [WC-1:0]    sample_q;
  logic [WC-1:0]    sample_d;

  logic             lane_clear_s;
  logic             lane_en_s;
  logic [ACC_W-1:0] lane_ext_s [NUM_LANES];
  logic [ACC_W-1:0] final_s;

  // Lane l serves side l%2 and distance block l/2; taps walk outward from the centre
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int BLK  = l / 2;
    localparam int W_L  = lane_width(WC, (BLK * LANE_LEN) / SEG_LEN);
    localparam int LA_W = W_L + ACC_GUARD;

    logic [W_L-1:0]      op_s [LANE_LEN];
    logic [LANE_LEN-1:0] add_s;
    logic [LA_W-1:0]     acc_s;

    for (genvar i = 0; i < LANE_LEN; i++) begin : g_tap
      localparam int D   = BLK * LANE_LEN + i;
      localparam int TAP = ((l % 2) == 1) ? (HALF + D) : (HALF - 1 - D);
      assign op_s[i]  = H_matrix[TAP][W_L-1:0];
      assign add_s[i] = s_q[TAP];
      if (W_L < WC) begin : g_drop
        logic unused_hi_s;
        assign unused_hi_s = ^H_matrix[TAP][WC-1:W_L];
      end
    end

    mca_seg_lane #(
      .W_IN     (W_L),
      .LANE_LEN (LANE_LEN),
      .ACC_GUARD(ACC_GUARD)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear_i(lane_clear_s),
      .en_i   (lane_en_s),
      .step_i (step_q),
      .op_i   (op_s),
      .add_i  (add_s),
      .acc_o  (acc_s)
    );

    assign lane_ext_s[l] = {{(ACC_W - LA_W){acc_s[LA_W-1]}}, acc_s};
  end

  // Lane control strobes and the running reduce sum including the current lane
  always_comb begin
    lane_clear_s = (state_q == MCA_IDLE) && start;
    lane_en_s    = (state_q == MCA_ACCUM);
    final_s      = red_acc_q + lane_ext_s[lane_idx_q];
  end

`ifdef MCA_SAT_EN
  // Clamp when the bits above the sample sign bit do not all agree with it
  always_comb begin
    if ((&final_s[ACC_W-1:WC-1]) || (~|final_s[ACC_W-1:WC-1])) begin
      sample_d = final_s[WC-1:0];
    end else if (final_s[ACC_W-1]) begin
      sample_d = {1'b1, {(WC-1){1'b0}}};
    end else begin
      sample_d = {1'b0, {(WC-1){1'b1}}};
    end
  end
`else
  assign sample_d = final_s[WC-1:0];
`endif

  // Control FSM, reduce accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= MCA_IDLE;
      step_q         <= '0;
      lane_idx_q     <= '0;
      s_q            <= '0;
      red_acc_q      <= '0;
      start_ready_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      sample_q       <= '0;
    end else begin
      case (state_q)
        MCA_IDLE: begin
          if (start) begin
            state_q       <= MCA_ACCUM;
            s_q           <= S_matrix;
            step_q        <= '0;
            lane_idx_q    <= '0;
            red_acc_q     <= '0;
            start_ready_q <= 1'b0;
          end
        end
        MCA_ACCUM: begin
          if (step_q == SW'(LANE_LEN - 1)) begin
            state_q    <= MCA_REDUCE;
            step_q     <= '0;
            lane_idx_q <= '0;
            red_acc_q  <= '0;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        MCA_REDUCE: begin
          red_acc_q <= final_s;
          if (lane_idx_q == LIW'(NUM_LANES - 1)) begin
            state_q        <= MCA_DONE;
            lane_idx_q     <= '0;
            sample_q       <= sample_d;
            sample_valid_q <= 1'b1;
          end else begin
            lane_idx_q <= lane_idx_q + LIW'(1);
          end
        end
        MCA_DONE: begin
          if (sample_ready) begin
            state_q        <= MCA_IDLE;
            sample_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= MCA_IDLE;
        end
      endcase
    end
  end

  assign start_ready  = start_ready_q;
  assign sample_valid = sample_valid_q;
  assign sample       = sample_q;

endmodule

// File: tb/tb_mca_segmented_acc.sv
// Randomized bench for mca_segmented_acc against a tap-level reference model,
// plus a small K=32 instance for the two-lane boundary configuration.
module tb_mca_segmented_acc;

  localparam int RED[8] = '{0, 1, 2, 3, 4, 5, 7, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_s = 1'b1;
  logic                start_s = 1'b0;
  logic                ready_s = 1'b0;
  logic signed [31:0]  h_s [256];
  logic [255:0]        s_s = '0;
  logic                start_ready;
  logic signed [31:0]  sample;
  logic                sample_valid;

  logic                start2_s = 1'b0;
  logic signed [31:0]  h2_s [32];
  logic [31:0]         s2_s = '0;
  logic                start_ready2;
  logic signed [31:0]  sample2;
  logic                sample_valid2;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  mca_segmented_acc dut (
    .clk(clk), .reset(reset_s), .start(start_s), .start_ready(start_ready),
    .H_matrix(h_s), .S_matrix(s_s), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(ready_s)
  );

  mca_segmented_acc #(.K(32)) dut2 (
    .clk(clk), .reset(reset_s), .start(start2_s), .start_ready(start_ready2),
    .H_matrix(h2_s), .S_matrix(s2_s), .sample(sample2),
    .sample_valid(sample_valid2), .sample_ready(1'b1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic int lw(input int blk);
    int seg;
    seg = (blk * 16) / 32;
    if (seg > 7) seg = 7;
    return 32 - RED[seg];
  endfunction

  // Sum of +/-H[k] with per-distance operand truncation and per-lane wrap
  function automatic logic [31:0] model(input logic signed [31:0] h [256], input logic [255:0] s, input int kk);
    longint lane [16];
    longint tot;
    int side, d, b;
    for (int j = 0; j < 16; j++) lane[j] = 0;
    for (int k = 0; k < kk; k++) begin
      side = (k >= kk / 2) ? 1 : 0;
      d    = (side == 1) ? (k - kk / 2) : (kk / 2 - 1 - k);
      b    = d / 16;
      if (s[k]) lane[2 * b + side] += sx(longint'(h[k]), lw(b));
      else      lane[2 * b + side] -= sx(longint'(h[k]), lw(b));
    end
    tot = 0;
    for (int j = 0; j < 16; j++) tot += sx(lane[j], lw(j / 2) + 4);
`ifdef MCA_SAT_EN
    if (tot > 64'sd2147483647) tot = 64'sd2147483647;
    else if (tot < -64'sd2147483648) tot = -64'sd2147483648;
`endif
    return tot[31:0];
  endfunction

  logic        m_idle, m_valid;
  int          m_cnt;
  logic [31:0] m_sample, m_pending;

  // Cycle reference for the K=256 instance: accept, 32 busy edges, then hold until taken
  always @(posedge clk) begin
    if (reset_s) begin
      m_idle = 1'b1; m_valid = 1'b0; m_cnt = 0; m_sample = 32'h0;
    end else if (m_idle) begin
      if (start_s) begin
        m_idle = 1'b0; m_cnt = 0; m_pending = model(h_s, s_s, 256);
      end
    end else if (!m_valid) begin
      m_cnt++;
      if (m_cnt == 32) begin
        m_valid = 1'b1; m_sample = m_pending;
      end
    end else if (ready_s) begin
      m_valid = 1'b0; m_idle = 1'b1;
    end
  end

  // Compare every output of the K=256 instance with the reference each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_start_ready", {31'b0, start_ready}, {31'b0, m_idle});
      chk("cyc_sample_valid", {31'b0, sample_valid}, {31'b0, m_valid});
      chk("cyc_sample", sample, m_sample);
    end
  end

  task automatic set_h(input logic [31:0] v);
    for (int j = 0; j < 256; j++) h_s[j] = v;
  endtask

  task automatic rand_s();
    for (int j = 0; j < 8; j++) s_s[j * 32 +: 32] = $urandom();
  endtask

  task automatic do_txn(input int hold, input logic use_exp, input logic [31:0] exp, input string nm);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    start_s = 1'b1;
    ready_s = (hold == 0);
    @(negedge clk);
    start_s = 1'b0;
    rand_s();
    lat = 1;
    while (!sample_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_valid"}, {31'b0, sample_valid}, 32'd1);
    chk({nm, "_latency"}, lat, 32'd33);
    if (use_exp) chk({nm, "_sample"}, sample, exp);
    held = sample;
    for (int c = 0; c < hold; c++) begin
      start_s = 1'b1;
      @(negedge clk);
      chk({nm, "_hold_sample"}, sample, held);
      chk({nm, "_hold_start_ready"}, {31'b0, start_ready}, 32'd0);
    end
    start_s = 1'b0;
    ready_s = 1'b1;
    @(negedge clk);
    chk({nm, "_idle_start_ready"}, {31'b0, start_ready}, 32'd1);
    chk({nm, "_idle_valid"}, {31'b0, sample_valid}, 32'd0);
    chk({nm, "_idle_sample"}, sample, held);
    ready_s = 1'b0;
  endtask

  task automatic run2(input logic use_exp, input logic [31:0] exp, input string nm);
    logic signed [31:0] tmp [256];
    logic [31:0] m;
    int lat;
    for (int j = 0; j < 256; j++) tmp[j] = (j < 32) ? h2_s[j] : 32'sd0;
    m = model(tmp, {224'b0, s2_s}, 32);
    if (use_exp) chk({nm, "_model"}, m, exp);
    @(negedge clk);
    start2_s = 1'b1;
    @(negedge clk);
    start2_s = 1'b0;
    lat = 1;
    while (!sample_valid2 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_valid"}, {31'b0, sample_valid2}, 32'd1);
    chk({nm, "_latency"}, lat, 32'd19);
    chk({nm, "_sample"}, sample2, m);
    @(negedge clk);
    chk({nm, "_start_ready"}, {31'b0, start_ready2}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] tmp [256];
    logic [31:0] exp4;
    set_h(32'h0);
    for (int j = 0; j < 32; j++) h2_s[j] = 32'sd0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset_s = 1'b0;
    chk("reset_start_ready", {31'b0, start_ready}, 32'd1);
    chk("reset_valid", {31'b0, sample_valid}, 32'd0);
    chk("reset_sample", sample, 32'h0);

    set_h(32'h1); s_s = '1;
    chk("model_all_add", model(h_s, s_s, 256), 32'd256);
    do_txn(0, 1'b1, 32'd256, "all_add");

    set_h(32'h1); s_s = '0;
    chk("model_all_sub", model(h_s, s_s, 256), 32'hFFFF_FF00);
    do_txn(1, 1'b1, 32'hFFFF_FF00, "all_sub");

    // Tap 1 lies in the outermost lane (29-bit operand), so bit 29 truncates away
    set_h(32'h0); h_s[0] = 32'h0000_0100; h_s[1] = 32'h2000_0000; s_s = '1;
    chk("model_trunc", model(h_s, s_s, 256), 32'h0000_0100);
    do_txn(0, 1'b1, 32'h0000_0100, "trunc");

`ifdef MCA_SAT_EN
    exp4 = 32'h7FFF_FFFF;
`else
    exp4 = 32'hFFFF_FFC0;
`endif
    set_h(32'h0); s_s = '1;
    for (int j = 96; j < 160; j++) h_s[j] = 32'h7FFF_FFFF;
    chk("model_centre", model(h_s, s_s, 256), exp4);
    do_txn(0, 1'b1, exp4, "centre");

    // Abort in the middle of ACCUM
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (8) @(negedge clk);
    reset_s = 1'b1;
    @(negedge clk);
    chk("abort_start_ready", {31'b0, start_ready}, 32'd1);
    chk("abort_valid", {31'b0, sample_valid}, 32'd0);
    chk("abort_sample", sample, 32'h0);
    reset_s = 1'b0;
    for (int j = 0; j < 256; j++) h_s[j] = $urandom();
    rand_s();
    do_txn(0, 1'b0, 32'h0, "after_abort");

    for (int j = 0; j < 256; j++) h_s[j] = $urandom();
    rand_s();
    do_txn(5, 1'b0, 32'h0, "backpressure");

    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < 256; j++) h_s[j] = $urandom();
      rand_s();
      do_txn($urandom_range(0, 3), 1'b0, 32'h0, "rnd");
    end

    for (int j = 0; j < 32; j++) h2_s[j] = 32'sd1;
    s2_s = '1;
    run2(1'b1, 32'd32, "k32_all_add");
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 32; j++) h2_s[j] = $urandom();
      s2_s = $urandom();
      run2(1'b0, 32'h0, "k32_rnd");
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
